fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction fetch stage that sits directly upstream of the instruction decoder. It holds the PC, issues in-order requests to instruction memory under credit control, and buffers returned words with their PCs in a small FIFO. It presents {pc, instr} to decode over a valid/ready handshake. Branch/jump redirects flush the buffer and discard stale in-flight responses.

Parameters:
DATA_WIDTH, 32, instruction and PC width
RESET_PC, 32'h0000_0000, PC loaded on reset
DEPTH, 4, FIFO entries; also the maximum of outstanding requests plus buffered words (power of 2, ≥2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  DATA_WIDTH  byte address of request
imem_rsp_valid  in  1  response word valid (in order, latency ≥1 cycle, no backpressure)
imem_rsp_data  in  DATA_WIDTH  returned instruction
redirect_valid  in  1  branch/jump taken, flush fetch
redirect_pc  in  DATA_WIDTH  new fetch PC
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts instruction
if_instr  out  DATA_WIDTH  instruction to decoder (instr_in)
if_pc  out  DATA_WIDTH  PC of if_instr

Behaviour:
- Reset (rst high at a clk edge): req_pc=RESET_PC, rsp_pc=RESET_PC, inflight=0, drop_cnt=0, FIFO empty. While rst is high and in the cycle after: imem_req_valid=0, if_valid=0. Reset mid-operation abandons all in-flight responses. The environment guarantees that no responses arrive after reset for requests issued before reset.
- Credit: imem_req_valid = !rst && !redirect_valid && (inflight + fifo_count < DEPTH), using registered values only.
- imem_addr = req_pc. On accept (valid && ready): req_pc += 4 (mod 2^DATA_WIDTH, natural wrap), inflight += 1.
- Response: each imem_rsp_valid decrements inflight. If drop_cnt>0, the word is discarded and drop_cnt decrements. Otherwise {rsp_pc, data} is pushed into the FIFO and rsp_pc += 4.
- Push latency: a response in cycle N appears at if_valid/if_instr in cycle N+1. With memory latency 1, the first instruction after reset or redirect is valid 2 cycles after the request is accepted.
- Output: if_valid = FIFO not empty; if_instr/if_pc = FIFO head. Pop on if_valid && if_ready. if_instr/if_pc stay stable while if_valid && !if_ready.
- Full throughput: with DEPTH=4, latency 1 and if_ready held high, one instruction per cycle.
- Redirect (redirect_valid high in cycle N):
  - No request is issued in cycle N.
  - FIFO flushed at end of N, so if_valid=0 in N+1. A pop in cycle N is ignored.
  - req_pc=rsp_pc=redirect_pc.
  - A response arriving in cycle N is discarded.
  - drop_cnt = inflight − (imem_rsp_valid ? 1 : 0), and inflight is reduced by that response.
  - First request at redirect_pc goes out in N+1 if credit allows.
- Back-to-back redirects: the last one wins, and drop counts accumulate correctly.
- Simultaneous push and pop on a full FIFO is legal. Credit prevents overflow; overflow or underflow is a bug, so assert it in the bench.
- redirect_pc is not checked for alignment; the low 2 bits pass through.

Decomposition:
- Shared package riscv_pkg holds DATA_WIDTH/XLEN, RESET_PC default, the PC increment constant (4), and typedef fetch_entry_t {logic [XLEN-1:0] pc; logic [XLEN-1:0] instr;}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, DEPTH entries, with push, pop, flush, count, empty and full; flush has priority over push and pop.

Test Plan:
1. Reset then free-run (mem latency 1, rsp = addr ^ 32'hA5A5_0000, if_ready=1) -> addresses 0,4,8,…; if_pc/if_instr pairs match; after fill, one instruction per cycle.
2. Hold if_ready=0 for 10 cycles -> exactly 4 requests issued, then imem_req_valid=0; head stays at pc=0 and is stable; on release, order 0,4,8,C is preserved with no loss.
3. Redirect to 32'h0000_0100 while 3 requests are in flight (latency 3) -> the 3 stale responses are dropped, if_valid=0 the next cycle, first delivered if_pc=0x100.
4. Redirect in the same cycle as a response and as a decode pop -> the response is dropped, the pop is ignored, no stale PC ever appears at if_pc.
5. rst asserted mid-stream with a full FIFO -> if_valid and imem_req_valid are 0 the following cycle; restart fetches from RESET_PC.
6. redirect_pc=32'hFFFF_FFFC -> fetched PCs are FFFF_FFFC, then 0000_0000, wrapping cleanly; imem_req_ready toggled randomly with no duplicate or skipped PCs.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: word width, reset vector and the fetch entry payload.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush overrides push and pop.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [CW-1:0]  cnt;
    logic           do_pop;
    logic           do_push;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    // A pop frees a slot in the same cycle, so a full FIFO may push and pop together.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: credit-limited in-order imem requests, response buffering and redirect flush.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH = XLEN,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned            DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [DATA_WIDTH-1:0] if_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] req_pc;
    logic [DATA_WIDTH-1:0] rsp_pc;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         drop_cnt;
    logic [CW-1:0]         fifo_count;
    logic                  rst_q;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  credit_ok;
    logic                  req_fire;
    logic                  rsp_keep;
    fetch_entry_t          push_entry;
    fetch_entry_t          head_entry;

    // Credit covers both words still in memory and words already buffered.
    assign credit_ok      = !fifo_full && (({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(DEPTH));
    assign imem_req_valid = !rst && !rst_q && !redirect_valid && credit_ok;
    assign imem_addr      = req_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);

    assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};
    assign if_valid   = !fifo_empty;
    assign if_pc      = head_entry.pc;
    assign if_instr   = head_entry.instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc   <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
            rst_q    <= 1'b1;
        end else begin
            rst_q <= 1'b0;
            if (redirect_valid) begin
                // Everything still outstanding belongs to the old path and must be discarded.
                req_pc   <= redirect_pc;
                rsp_pc   <= redirect_pc;
                inflight <= inflight - CW'(imem_rsp_valid);
                drop_cnt <= inflight - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    req_pc <= req_pc + DATA_WIDTH'(PC_INC);
                end
                if (rsp_keep) begin
                    rsp_pc <= rsp_pc + DATA_WIDTH'(PC_INC);
                end
                inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
                if (imem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (if_valid && if_ready),
        .flush     (redirect_valid),
        .head      (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule
